polyplay_vram_arb: RTL and testbench

POLYPLAY_VRAM_ARB -- requirements
Module: polyplay_vram_arb

---
 rtl/polyplay_vram_arb_if.sv | 37 +++
 rtl/polyplay_vram_arb.sv | 176 +++++++++++++++++
 tb/tb_polyplay_vram_arb.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/polyplay_vram_arb_if.sv
// Bus bundle for the Polyplay video RAM arbiter: video fetch port, CPU port,
// RAM port and the overrun flag. "slave" is the arbiter side, "master" the surroundings.
interface polyplay_vram_arb_if #(
    parameter int AW = 11,
    parameter int DW = 8
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          vid_overrun;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vid_data, vid_valid, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata,
        output vid_overrun
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vid_data, vid_valid, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata,
        input  vid_overrun
    );
endinterface

// File: rtl/polyplay_vram_arb.sv
// Single-port video RAM arbiter: one access slot per cycle shared between video
// fetches (default winner, one-deep pending buffer) and a CPU port with anti-starvation.
module polyplay_vram_arb #(
    parameter int AW       = 11,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    polyplay_vram_arb_if.slave    bus
);

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_VID    = 2'd1,
        TAG_CPU_RD = 2'd2,
        TAG_CPU_WR = 2'd3
    } tag_e;

    logic          pend_valid_q, pend_valid_d;
    logic [AW-1:0] pend_addr_q,  pend_addr_d;
    logic [3:0]    wait_cnt_q,   wait_cnt_d;
    logic          cpu_busy_q,   cpu_busy_d;
    tag_e          tag_s1_q,     tag_s1_d;
    tag_e          tag_s2_q,     tag_s2_d;
    logic [AW-1:0] ram_addr_q,   ram_addr_d;
    logic          ram_we_q,     ram_we_d;
    logic [DW-1:0] ram_wdata_q,  ram_wdata_d;
    logic [DW-1:0] vid_data_q,   vid_data_d;
    logic          vid_valid_q,  vid_valid_d;
    logic [DW-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic          cpu_ack_q,    cpu_ack_d;
    logic          overrun_q,    overrun_d;

    logic          cpu_pend_s;
    logic          force_cpu_s;
    logic          grant_cpu_s;
    logic          grant_vid_s;
    logic [AW-1:0] vid_issue_addr_s;

    // Slot arbitration, pending buffer, wait counter and read-return pipeline
    always_comb begin
        pend_valid_d     = pend_valid_q;
        pend_addr_d      = pend_addr_q;
        wait_cnt_d       = wait_cnt_q;
        cpu_busy_d       = cpu_busy_q;
        tag_s1_d         = TAG_NONE;
        tag_s2_d         = tag_s1_q;
        ram_addr_d       = ram_addr_q;
        ram_we_d         = 1'b0;
        ram_wdata_d      = ram_wdata_q;
        vid_data_d       = vid_data_q;
        vid_valid_d      = 1'b0;
        cpu_rdata_d      = cpu_rdata_q;
        cpu_ack_d        = 1'b0;
        overrun_d        = overrun_q;
        grant_cpu_s      = 1'b0;
        grant_vid_s      = 1'b0;
        vid_issue_addr_s = pend_addr_q;

        cpu_pend_s  = bus.cpu_req & ~cpu_busy_q;
        force_cpu_s = cpu_pend_s & (wait_cnt_q == 4'(MAX_WAIT));

        // The buffered fetch always goes before a newly arriving one
        if (force_cpu_s) begin
            grant_cpu_s = 1'b1;
            if (bus.vid_req && pend_valid_q) begin
                overrun_d = 1'b1;
            end else if (bus.vid_req) begin
                pend_valid_d = 1'b1;
                pend_addr_d  = bus.vid_addr;
            end else begin
                pend_valid_d = pend_valid_q;
            end
        end else if (pend_valid_q) begin
            grant_vid_s      = 1'b1;
            vid_issue_addr_s = pend_addr_q;
            if (bus.vid_req) begin
                pend_addr_d = bus.vid_addr;
            end else begin
                pend_valid_d = 1'b0;
            end
        end else if (bus.vid_req) begin
            grant_vid_s      = 1'b1;
            vid_issue_addr_s = bus.vid_addr;
        end else if (cpu_pend_s) begin
            grant_cpu_s = 1'b1;
        end else begin
            grant_cpu_s = 1'b0;
        end

        if (grant_cpu_s) begin
            ram_addr_d  = bus.cpu_addr;
            ram_wdata_d = bus.cpu_wdata;
            ram_we_d    = bus.cpu_we;
            cpu_busy_d  = 1'b1;
            wait_cnt_d  = 4'd0;
            if (bus.cpu_we) begin
                tag_s1_d = TAG_CPU_WR;
            end else begin
                tag_s1_d = TAG_CPU_RD;
            end
        end else if (grant_vid_s) begin
            ram_addr_d = vid_issue_addr_s;
            tag_s1_d   = TAG_VID;
        end else begin
            tag_s1_d = TAG_NONE;
        end

        if (cpu_pend_s && !grant_cpu_s && (wait_cnt_q != 4'hF)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = wait_cnt_d;
        end

        // ram_rdata now holds the word addressed two edges ago
        if (tag_s2_q == TAG_VID) begin
            vid_valid_d = 1'b1;
            vid_data_d  = bus.ram_rdata;
        end else if (tag_s2_q == TAG_CPU_RD) begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = bus.ram_rdata;
            cpu_busy_d  = 1'b0;
        end else if (tag_s2_q == TAG_CPU_WR) begin
            cpu_ack_d   = 1'b1;
            cpu_busy_d  = 1'b0;
        end else begin
            vid_valid_d = 1'b0;
        end
    end

    // State and output registers; reset also discards in-flight tags
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= {AW{1'b0}};
            wait_cnt_q   <= 4'd0;
            cpu_busy_q   <= 1'b0;
            tag_s1_q     <= TAG_NONE;
            tag_s2_q     <= TAG_NONE;
            ram_addr_q   <= {AW{1'b0}};
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= {DW{1'b0}};
            vid_data_q   <= {DW{1'b0}};
            vid_valid_q  <= 1'b0;
            cpu_rdata_q  <= {DW{1'b0}};
            cpu_ack_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_busy_q   <= cpu_busy_d;
            tag_s1_q     <= tag_s1_d;
            tag_s2_q     <= tag_s2_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            vid_data_q   <= vid_data_d;
            vid_valid_q  <= vid_valid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.vid_data    = vid_data_q;
    assign bus.vid_valid   = vid_valid_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.vid_overrun = overrun_q;

endmodule

// File: tb/tb_polyplay_vram_arb.sv
// Directed bench for polyplay_vram_arb: stimulus pushes expected strobes (data and
// cycle) into queues; a negedge monitor pops and compares whenever a strobe appears.
module tb_polyplay_vram_arb;
    localparam int AW = 11;
    localparam int DW = 8;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t vid_q[$];
    exp_t cpu_q[$];
    logic [7:0] mem [0:2047];
    logic       mem_init = 1'b0;

    polyplay_vram_arb_if #(.AW(AW), .DW(DW)) bus ();

    polyplay_vram_arb #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] preset(input int a);
        logic [7:0] k;
        k = 8'(a - 256);
        if (a == 'h123)                    return 8'h5A;
        else if (a == 'h010)               return 8'h77;
        else if (a == 'h020)               return 8'h3C;
        else if (a >= 256 && a < 256 + 13) return k * 8'h11 + 8'h01;
        else                               return 8'h00;
    endfunction

    // Synchronous RAM model, one-cycle read latency, contents preset on the first edge
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= preset(i);
            mem_init <= 1'b1;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (bus.vid_valid) begin
            if (vid_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL vid_unexpected: vid_valid=1 at cycle %0d, expected no strobe", cyc);
            end else begin
                e = vid_q.pop_front();
                chk("vid_data", int'(bus.vid_data), int'(e.data));
                chk("vid_cycle", cyc, e.cyc);
            end
        end
        if (bus.cpu_ack) begin
            if (cpu_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cpu_unexpected: cpu_ack=1 at cycle %0d, expected no ack", cyc);
            end else begin
                e = cpu_q.pop_front();
                chk("cpu_rdata", int'(bus.cpu_rdata), int'(e.data));
                chk("cpu_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_vid_valid"},   int'(bus.vid_valid),   0);
        chk({tag, "_cpu_ack"},     int'(bus.cpu_ack),     0);
        chk({tag, "_ram_we"},      int'(bus.ram_we),      0);
        chk({tag, "_vid_overrun"}, int'(bus.vid_overrun), 0);
        chk({tag, "_ram_addr"},    int'(bus.ram_addr),    0);
        chk({tag, "_ram_wdata"},   int'(bus.ram_wdata),   0);
        chk({tag, "_vid_data"},    int'(bus.vid_data),    0);
        chk({tag, "_cpu_rdata"},   int'(bus.cpu_rdata),   0);
    endtask

    task automatic start_cpu(input logic we, input logic [10:0] a, input logic [7:0] d,
                             input logic [7:0] exp_rd, input int lat, input bit push);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        if (push) cpu_q.push_back('{exp_rd, cyc + lat});
    endtask

    task automatic finish_cpu(output int we_seen);
        bit got;
        got     = 1'b0;
        we_seen = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            if (bus.ram_we) we_seen++;
            if (bus.cpu_ack) got = 1'b1;
        end
        chk("cpu_ack_seen", int'(got), 1);
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ws;
        int c;
        int vslot [12];
        int k;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = 11'h000;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 11'h000;
        bus.cpu_wdata = 8'h00;

        repeat (3) @(negedge clk);
        chk_zero("reset");

        // Lone video read issued in the first cycle after reset release
        reset        = 1'b0;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 11'h123;
        vid_q.push_back('{8'h5A, cyc + 3});
        @(negedge clk);
        bus.vid_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("vid_data_hold", int'(bus.vid_data), 'h5A);

        // CPU write then read-back
        start_cpu(1'b1, 11'h7FF, 8'hC3, 8'h00, 3, 1'b1);
        finish_cpu(ws);
        chk("write_we_cycles", ws, 1);
        repeat (2) @(negedge clk);
        start_cpu(1'b0, 11'h7FF, 8'h00, 8'hC3, 3, 1'b1);
        finish_cpu(ws);
        chk("read_we_cycles", ws, 0);
        repeat (2) @(negedge clk);

        // Collision: video first, CPU one slot later
        bus.vid_req  = 1'b1;
        bus.vid_addr = 11'h123;
        vid_q.push_back('{8'h5A, cyc + 3});
        start_cpu(1'b0, 11'h010, 8'h00, 8'h77, 4, 1'b1);
        @(negedge clk);
        bus.vid_req = 1'b0;
        finish_cpu(ws);
        repeat (2) @(negedge clk);

        // A write leaves cpu_rdata at the last read value
        start_cpu(1'b1, 11'h010, 8'h55, 8'h77, 3, 1'b1);
        finish_cpu(ws);
        chk("write2_we_cycles", ws, 1);
        repeat (3) @(negedge clk);

        // Starvation: video every cycle, CPU held; fetch 11 is lost at the second forced grant
        c     = cyc;
        vslot = '{0, 1, 2, 3, 5, 6, 7, 8, 9, 10, 12, 13};
        for (int j = 0; j < 12; j++) begin
            k = (j < 11) ? j : 12;
            vid_q.push_back('{preset(256 + k), c + 3 + vslot[j]});
        end
        start_cpu(1'b0, 11'h020, 8'h00, 8'h3C, 7, 1'b1);
        cpu_q.push_back('{8'h3C, c + 14});
        for (int j = 0; j < 13; j++) begin
            bus.vid_req  = 1'b1;
            bus.vid_addr = 11'(256 + j);
            if (j == 11) chk("overrun_not_yet", int'(bus.vid_overrun), 0);
            @(negedge clk);
        end
        bus.vid_req = 1'b0;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        chk("overrun_set", int'(bus.vid_overrun), 1);
        repeat (6) @(negedge clk);
        chk("overrun_sticky", int'(bus.vid_overrun), 1);

        // Reset one edge after a CPU read is issued: no ack, everything cleared
        start_cpu(1'b0, 11'h7FF, 8'h00, 8'h00, 3, 1'b0);
        @(negedge clk);
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Normal operation after reset, including the earlier write to 0x010
        start_cpu(1'b0, 11'h7FF, 8'h00, 8'hC3, 3, 1'b1);
        finish_cpu(ws);
        @(negedge clk);
        bus.vid_req  = 1'b1;
        bus.vid_addr = 11'h010;
        vid_q.push_back('{8'h55, cyc + 3});
        @(negedge clk);
        bus.vid_req = 1'b0;
        repeat (5) @(negedge clk);

        chk("vid_queue_drained", vid_q.size(), 0);
        chk("cpu_queue_drained", cpu_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
